// File: rtl/nes_pad_responder_pkg.sv
// Shared definitions for the NES controller pad responder: FSM states,
// button bit positions on the wire, frame length and the turbo helper.
package nes_pad_responder_pkg;

  // Protocol states; LOAD is the transparent parallel-load phase.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } padState_t;

  // Bit positions of each button in the 8-bit wire word (0 = pressed).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Number of data bits in one report frame.
  localparam logic [3:0] FRAME_LEN = 4'd8;

  // All buttons released, the idle value of the shift register.
  localparam logic [7:0] ALL_RELEASED = 8'hFF;

  // Force A and/or B to released while the turbo phase is active.
  function automatic logic [7:0] applyTurbo(input logic [7:0] buttons,
                                            input logic [1:0] turbo,
                                            input logic       phase);
    logic [7:0] result;
    result = buttons;
    if (phase && turbo[0]) result[BTN_A] = 1'b1;
    if (phase && turbo[1]) result[BTN_B] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/nes_pin_filter.sv
// Synchronizer chain followed by a stability filter for one asynchronous
// host pin. The filtered output only moves once the synchronized pin has
// disagreed with it for FILTER_CYCLES consecutive clocks.
module nes_pin_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_filtered
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syncPin;
  logic                   filt_q;
  logic [CW-1:0]          stableCnt_q;

  assign syncPin    = sync_q[SYNC_STAGES-1];
  assign o_filtered = filt_q;

  // Metastability chain: pin enters at stage 0 and walks up the chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i_pin;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q      <= 1'b0;
      stableCnt_q <= '0;
    end else if (syncPin != filt_q) begin
      if (stableCnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_q      <= syncPin;
        stableCnt_q <= '0;
      end else begin
        stableCnt_q <= stableCnt_q + 1'b1;
      end
    end else begin
      stableCnt_q <= '0;
    end
  end

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: answers the console's latch/clock protocol with
// an 8-bit button report on o_serial_data, A first.
// Optional turbo on A/B is built only when NES_PAD_TURBO_EN is defined.
module nes_pad_responder
  import nes_pad_responder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int LINK_TIMEOUT  = 1350000,
  parameter int TURBO_PERIOD  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data_latch,
  input  logic       i_data_clock,
  input  logic [7:0] i_button_state,
  input  logic [1:0] i_turbo,
  output logic       o_serial_data,
  output logic       o_frame_done,
  output logic       o_link_active,
  output logic [7:0] o_latched_state
);

  localparam int WDOG_W = $clog2(LINK_TIMEOUT + 1);

  logic latchFilt;
  logic clkFilt;
  logic latchPrev_q;
  logic clkPrev_q;
  logic latchRise;
  logic latchFall;
  logic clkRise;

  padState_t   state_q;
  logic [7:0]  shift_q;
  logic [3:0]  bitCnt_q;
  logic        frameDone_q;
  logic [7:0]  latched_q;
  logic [7:0]  loadValue;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              seen_q, seen_d;
  logic              linkActive_q;

  nes_pin_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch_filter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pin     (i_data_latch),
    .o_filtered(latchFilt)
  );

  nes_pin_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clock_filter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pin     (i_data_clock),
    .o_filtered(clkFilt)
  );

  // Remember last filtered levels so edges are seen on clean signals only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      latchPrev_q <= 1'b0;
      clkPrev_q   <= 1'b0;
    end else begin
      latchPrev_q <= latchFilt;
      clkPrev_q   <= clkFilt;
    end
  end

  assign latchRise = latchFilt & ~latchPrev_q;
  assign latchFall = ~latchFilt & latchPrev_q;
  assign clkRise   = clkFilt & ~clkPrev_q;

`ifdef NES_PAD_TURBO_EN
  localparam int TURBO_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [TURBO_W-1:0] turboCnt_q;
  logic               turboPhase_q;

  // Count latch frames and flip the turbo phase every TURBO_PERIOD of them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      turboCnt_q   <= '0;
      turboPhase_q <= 1'b0;
    end else if (latchFall) begin
      if (turboCnt_q == TURBO_W'(TURBO_PERIOD - 1)) begin
        turboCnt_q   <= '0;
        turboPhase_q <= ~turboPhase_q;
      end else begin
        turboCnt_q <= turboCnt_q + 1'b1;
      end
    end
  end

  assign loadValue = applyTurbo(i_button_state, i_turbo, turboPhase_q);
`else
  logic unusedTurbo;

  assign unusedTurbo = ^i_turbo;
  assign loadValue   = i_button_state;
`endif

  // Protocol FSM: latch level overrides everything, then load/shift/saturate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shift_q     <= ALL_RELEASED;
      bitCnt_q    <= 4'd0;
      frameDone_q <= 1'b0;
      latched_q   <= ALL_RELEASED;
    end else begin
      frameDone_q <= 1'b0;
      if (latchFilt) begin
        state_q <= LOAD;
        shift_q <= loadValue;
      end else begin
        case (state_q)
          LOAD: begin
            if (latchFall) begin
              state_q   <= SHIFT;
              latched_q <= shift_q;
              bitCnt_q  <= 4'd0;
            end
          end
          SHIFT, DONE: begin
            if (clkRise) begin
              shift_q <= {1'b1, shift_q[7:1]};
              if (bitCnt_q != FRAME_LEN) begin
                bitCnt_q <= bitCnt_q + 4'd1;
              end
              if (bitCnt_q == FRAME_LEN - 4'd1) begin
                frameDone_q <= 1'b1;
                state_q     <= DONE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Watchdog next state: restart on each latch, otherwise count up to the limit.
  always_comb begin
    wdog_d = wdog_q;
    seen_d = seen_q;
    if (latchRise) begin
      wdog_d = '0;
      seen_d = 1'b1;
    end else if (wdog_q < WDOG_W'(LINK_TIMEOUT)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog registers and the registered link-status flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdog_q       <= '0;
      seen_q       <= 1'b0;
      linkActive_q <= 1'b0;
    end else begin
      wdog_q       <= wdog_d;
      seen_q       <= seen_d;
      linkActive_q <= seen_d && (wdog_d < WDOG_W'(LINK_TIMEOUT));
    end
  end

  assign o_serial_data   = shift_q[0];
  assign o_frame_done    = frameDone_q;
  assign o_link_active   = linkActive_q;
  assign o_latched_state = latched_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: table of full frames plus hand
// sequences for overrun clocks, glitches, aborts, link loss, reset and turbo.
module tb_nes_pad_responder;

  localparam int LINK_TO = 5000;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_data_latch;
  logic       i_data_clock;
  logic [7:0] i_button_state;
  logic [1:0] i_turbo;
  logic       o_serial_data;
  logic       o_frame_done;
  logic       o_link_active;
  logic [7:0] o_latched_state;

  int compared   = 0;
  int mismatched = 0;
  int pulseCount = 0;

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] expSerial;
    logic [7:0] expLatched;
  } vec_t;

  vec_t vecs[6];

  nes_pad_responder #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .LINK_TIMEOUT (LINK_TO),
    .TURBO_PERIOD (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_data_latch   (i_data_latch),
    .i_data_clock   (i_data_clock),
    .i_button_state (i_button_state),
    .i_turbo        (i_turbo),
    .o_serial_data  (o_serial_data),
    .o_frame_done   (o_frame_done),
    .o_link_active  (o_link_active),
    .o_latched_state(o_latched_state)
  );

  // 25 MHz system clock.
  always #20ns i_clk = ~i_clk;

  // Count every cycle the frame-done strobe is high.
  always @(posedge i_clk) begin
    if (o_frame_done === 1'b1) pulseCount++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic readBit(output logic b);
    @(negedge i_clk);
    b = o_serial_data;
  endtask

  task automatic latchPulse();
    i_data_latch = 1'b1;
    #12us;
    i_data_latch = 1'b0;
    #3us;
  endtask

  task automatic dataClock();
    i_data_clock = 1'b1;
    #3us;
    i_data_clock = 1'b0;
    #3us;
  endtask

  task automatic readFrame(input int clocks, output logic [7:0] bits);
    logic b;
    bits = 8'hFF;
    for (int i = 0; i < clocks; i++) begin
      if (i < 8) begin
        readBit(b);
        bits[i] = b;
      end
      dataClock();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] buttons, input logic [1:0] turbo,
                               input int clocks, output logic [7:0] bits);
    i_button_state = buttons;
    i_turbo        = turbo;
    latchPulse();
    readFrame(clocks, bits);
  endtask

  task automatic pulseReset();
    @(negedge i_clk);
    i_rst = 1'b1;
    #200ns;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1us;
  endtask

  initial begin
    logic [7:0] bits;
    logic       b;
    int         p0;

    vecs[0] = '{8'hFE, 8'hFE, 8'hFE};
    vecs[1] = '{8'h7F, 8'h7F, 8'h7F};
    vecs[2] = '{8'h55, 8'h55, 8'h55};
    vecs[3] = '{8'hAA, 8'hAA, 8'hAA};
    vecs[4] = '{8'h00, 8'h00, 8'h00};
    vecs[5] = '{8'h81, 8'h81, 8'h81};

    i_rst          = 1'b1;
    i_data_latch   = 1'b0;
    i_data_clock   = 1'b0;
    i_button_state = 8'hFF;
    i_turbo        = 2'b00;

    #100ns;
    @(negedge i_clk);
    checkOutput("reset serial", 32'(o_serial_data), 32'h1);
    checkOutput("reset frame_done", 32'(o_frame_done), 32'h0);
    checkOutput("reset link", 32'(o_link_active), 32'h0);
    checkOutput("reset latched", 32'(o_latched_state), 32'hFF);
    i_rst = 1'b0;
    #1us;

    // Table of complete frames.
    for (int v = 0; v < 6; v++) begin
      p0 = pulseCount;
      applyStimulus(vecs[v].buttons, 2'b00, 8, bits);
      checkOutput($sformatf("frame%0d serial", v), 32'(bits), 32'(vecs[v].expSerial));
      checkOutput($sformatf("frame%0d latched", v), 32'(o_latched_state), 32'(vecs[v].expLatched));
      checkOutput($sformatf("frame%0d pulses", v), 32'(pulseCount - p0), 32'd1);
      checkOutput($sformatf("frame%0d link", v), 32'(o_link_active), 32'h1);
    end

    // Overrun clocks after a complete frame.
    p0 = pulseCount;
    for (int i = 0; i < 4; i++) begin
      dataClock();
      readBit(b);
      checkOutput($sformatf("overrun%0d serial", i), 32'(b), 32'h1);
    end
    checkOutput("overrun pulses", 32'(pulseCount - p0), 32'd0);

    // Latch glitch two cycles wide must be rejected.
    i_button_state = 8'h00;
    @(negedge i_clk);
    i_data_latch = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_data_latch = 1'b0;
    repeat (20) @(negedge i_clk);
    checkOutput("glitch serial", 32'(o_serial_data), 32'h1);
    checkOutput("glitch latched", 32'(o_latched_state), 32'h81);

    // New latch after three clocks aborts the frame.
    p0 = pulseCount;
    i_button_state = 8'hFE;
    latchPulse();
    repeat (3) dataClock();
    applyStimulus(8'h7F, 2'b00, 8, bits);
    checkOutput("abort serial", 32'(bits), 32'h7F);
    checkOutput("abort first bit", 32'(bits[0]), 32'h1);
    checkOutput("abort pulses", 32'(pulseCount - p0), 32'd1);
    checkOutput("abort latched", 32'(o_latched_state), 32'h7F);

    // Latch and clock rising together: latch wins, frame restarts cleanly.
    p0 = pulseCount;
    i_button_state = 8'hFA;
    latchPulse();
    dataClock();
    @(negedge i_clk);
    i_data_latch = 1'b1;
    i_data_clock = 1'b1;
    #3us;
    i_data_clock = 1'b0;
    #9us;
    i_data_latch = 1'b0;
    #3us;
    readFrame(8, bits);
    checkOutput("collide serial", 32'(bits), 32'hFA);
    checkOutput("collide latched", 32'(o_latched_state), 32'hFA);
    checkOutput("collide pulses", 32'(pulseCount - p0), 32'd1);

    // Link loss after the timeout, recovery on the next latch.
    repeat (LINK_TO + 50) @(negedge i_clk);
    checkOutput("link lost", 32'(o_link_active), 32'h0);
    i_data_latch = 1'b1;
    repeat (20) @(negedge i_clk);
    checkOutput("link regained", 32'(o_link_active), 32'h1);
    i_data_latch = 1'b0;
    #3us;

    // Reset in the middle of a frame, then a clean frame afterwards.
    i_button_state = 8'h00;
    latchPulse();
    repeat (3) dataClock();
    readBit(b);
    checkOutput("midframe serial", 32'(b), 32'h0);
    #7ns;
    i_rst = 1'b1;
    #1ns;
    checkOutput("rst serial", 32'(o_serial_data), 32'h1);
    checkOutput("rst latched", 32'(o_latched_state), 32'hFF);
    checkOutput("rst link", 32'(o_link_active), 32'h0);
    #200ns;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1us;
    p0 = pulseCount;
    applyStimulus(8'hA5, 2'b00, 8, bits);
    checkOutput("post-rst serial", 32'(bits), 32'hA5);
    checkOutput("post-rst latched", 32'(o_latched_state), 32'hA5);
    checkOutput("post-rst pulses", 32'(pulseCount - p0), 32'd1);

    // Turbo on A with A and B held: only A toggles, every four frames.
    pulseReset();
    for (int f = 0; f < 8; f++) begin
      applyStimulus(8'hFC, 2'b01, 8, bits);
`ifdef NES_PAD_TURBO_EN
      checkOutput($sformatf("turbo frame%0d", f), 32'(bits), (f < 4) ? 32'hFC : 32'hFD);
`else
      checkOutput($sformatf("turbo frame%0d", f), 32'(bits), 32'hFC);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
